// File: rtl/wts_pkg.sv
// Shared constants, serializer state record and sample formatting for the
// wts I2S transmit path.
package wts_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int SLOT_BITS   = 16;
  localparam int SAMPLE_BITS = 12;
  localparam int CNT_W       = $clog2(FRAME_BITS);
  localparam int DIV_W       = 8;

  typedef struct packed {
    logic [DIV_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] sr;
    logic                  bclk;
    logic                  lrclk;
    logic                  sdata;
    logic                  strobe;
  } tx_state_t;

  // bit_cnt parks at the last bit so the first falling toggle loads a frame.
  localparam tx_state_t TX_IDLE = '{
    div_cnt: '0,
    bit_cnt: CNT_W'(FRAME_BITS - 1),
    sr:      '0,
    bclk:    1'b0,
    lrclk:   1'b0,
    sdata:   1'b0,
    strobe:  1'b0
  };

  // Left-justify a 12-bit sample in a 16-bit slot; offset-binary input
  // gets its MSB inverted to become two's complement.
  function automatic logic [SLOT_BITS-1:0] fmt_sample(
    input logic [SAMPLE_BITS-1:0] s,
    input logic                   signed_in
  );
    return {s[SAMPLE_BITS-1] ^ ~signed_in, s[SAMPLE_BITS-2:0],
            {(SLOT_BITS - SAMPLE_BITS){1'b0}}};
  endfunction

endpackage

// File: rtl/wts_i2s_tx_if.sv
// Sample input and I2S output bundle of the wts I2S transmitter.
interface wts_i2s_tx_if;
  import wts_pkg::*;

  logic                   enable;
  logic [SAMPLE_BITS-1:0] left_in;
  logic [SAMPLE_BITS-1:0] right_in;
  logic                   bclk;
  logic                   lrclk;
  logic                   sdata;
  logic                   sample_strobe;

  modport master (
    output enable, left_in, right_in,
    input  bclk, lrclk, sdata, sample_strobe
  );

  modport slave (
    input  enable, left_in, right_in,
    output bclk, lrclk, sdata, sample_strobe
  );

endinterface

// File: rtl/wts_i2s_tx.sv
// I2S transmitter: divides clk down to BCLK and shifts a 32-bit stereo frame
// (16-bit left then right slot, MSB first) out on each BCLK falling edge.
module wts_i2s_tx
  import wts_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SIGNED_IN = 0
) (
  input logic         clk,
  input logic         nreset,
  wts_i2s_tx_if.slave io
);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LR_RISE    = CNT_W'(SLOT_BITS - 1);
  localparam logic             SIGNED_BIT = (SIGNED_IN != 0);

  tx_state_t             st;
  tx_state_t             st_nxt;
  logic [CNT_W-1:0]      bit_nxt;
  logic [SLOT_BITS-1:0]  fmt_l;
  logic [SLOT_BITS-1:0]  fmt_r;

  assign bit_nxt = st.bit_cnt + 1'b1;
  assign fmt_l   = fmt_sample(io.left_in, SIGNED_BIT);
  assign fmt_r   = fmt_sample(io.right_in, SIGNED_BIT);

  always_comb begin
    // NOTE: start from the held state so every path assigns every field;
    // a missed default here would infer latches.
    st_nxt        = st;
    st_nxt.strobe = 1'b0;
    if (st.div_cnt == DIV_LAST) begin
      st_nxt.div_cnt = '0;
      st_nxt.bclk    = ~st.bclk;
      // All data movement happens on the bclk 1->0 toggle, so sdata and
      // lrclk are settled a full half-period before the next rising edge.
      if (st.bclk) begin
        st_nxt.bit_cnt = bit_nxt;
        st_nxt.lrclk   = (bit_nxt >= LR_RISE) && (bit_nxt != BIT_LAST);
        if (bit_nxt == '0) begin
          st_nxt.sr     = {fmt_l, fmt_r};
          st_nxt.sdata  = fmt_l[SLOT_BITS-1];
          st_nxt.strobe = 1'b1;
        end else begin
          st_nxt.sr    = st.sr << 1;
          st_nxt.sdata = st.sr[FRAME_BITS-2];
        end
      end
    end else begin
      st_nxt.div_cnt = st.div_cnt + 1'b1;
    end
  end

  // NOTE: non-blocking assignment for all registered state, so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      st <= TX_IDLE;
    end else if (!io.enable) begin
      st <= TX_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  assign io.bclk          = st.bclk;
  assign io.lrclk         = st.lrclk;
  assign io.sdata         = st.sdata;
  assign io.sample_strobe = st.strobe;

endmodule

// File: tb/tb_wts_i2s_tx.sv
// Self-checking bench for wts_i2s_tx: two instances (CLK_DIV=2 offset-binary,
// CLK_DIV=1 two's complement) with a frame scoreboard and bit-level monitor.
module tb_wts_i2s_tx;
  import wts_pkg::*;

  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  wts_i2s_tx_if if_a ();
  wts_i2s_tx_if if_b ();

  wts_i2s_tx #(.CLK_DIV(DIV_A), .SIGNED_IN(0)) u_dut_a (
    .clk(clk), .nreset(nreset), .io(if_a)
  );
  wts_i2s_tx #(.CLK_DIV(DIV_B), .SIGNED_IN(1)) u_dut_b (
    .clk(clk), .nreset(nreset), .io(if_b)
  );

  logic [1:0]       en_v;
  logic [1:0][11:0] l_v;
  logic [1:0][11:0] r_v;
  logic [1:0][3:0]  out_v;   // {bclk, lrclk, sdata, sample_strobe}

  assign if_a.enable   = en_v[0];
  assign if_a.left_in  = l_v[0];
  assign if_a.right_in = r_v[0];
  assign if_b.enable   = en_v[1];
  assign if_b.left_in  = l_v[1];
  assign if_b.right_in = r_v[1];
  assign out_v[0] = {if_a.bclk, if_a.lrclk, if_a.sdata, if_a.sample_strobe};
  assign out_v[1] = {if_b.bclk, if_b.lrclk, if_b.sdata, if_b.sample_strobe};

  typedef struct {
    int          sel;
    logic [11:0] l;
    logic [11:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          edge_n  = 0;
  logic        mon_on  = 1'b0;
  logic [1:0]  run_q;

  // The bench's view of "DUT is counting": enable/reset as seen at each edge.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) run_q <= '0;
    else         run_q <= en_v;
  end

  function automatic int div_of(input int sel);
    return (sel == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic string nm(input int sel, input string s);
    return $sformatf("%s %s", (sel == 0) ? "a" : "b", s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int idx);
    int s = vecs[idx].sel;
    l_v[s] = vecs[idx].l;
    r_v[s] = vecs[idx].r;
    if (s == 0) exp_q0.push_back({vecs[idx].el, vecs[idx].er});
    else        exp_q1.push_back({vecs[idx].el, vecs[idx].er});
  endtask

  // Edge 1 is the first rising clk edge that samples enable high.
  task automatic goto_edge(input int target);
    if (edge_n < target) begin
      repeat (target - edge_n) @(posedge clk);
      #1;
      edge_n = target;
    end
  endtask

  task automatic start_run(input int idx);
    load_vec(idx);
    en_v[vecs[idx].sel] = 1'b1;
    edge_n = 0;
  endtask

  // Frame k loads on edge 2D(1+32k); its bit n appears on edge 2D(1+32k+n).
  task automatic finish_run(input int first, input int count);
    int s = vecs[first].sel;
    int d = div_of(s);
    for (int k = 0; k < count; k++) begin
      goto_edge(2 * d * (1 + 32 * k + 5));
      if (k + 1 < count) load_vec(first + k + 1);
    end
    goto_edge(2 * d * (1 + 32 * count) - 1);
    en_v[s] = 1'b0;
    goto_edge(edge_n + 3);
    check(nm(s, "queue drained"), (s == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  initial begin : monitor
    int          since  [2];
    int          rcount [2];
    int          last_s [2];
    logic [31:0] acc    [2];
    logic [3:0]  prev   [2];
    logic [3:0]  o;
    logic        rise, fall, exp_sb, got_exp;
    logic [31:0] exp_f;
    int          cyc, n, d;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      since[i] = 0; rcount[i] = -1; last_s[i] = -1; acc[i] = '0; prev[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        o = out_v[i];
        d = div_of(i);
        if (!mon_on) begin
          since[i] = 0;
        end else if (!run_q[i]) begin
          check(nm(i, "idle outputs"), o, 0);
          since[i] = 0; rcount[i] = -1; last_s[i] = -1;
        end else begin
          rise = !prev[i][3] && o[3];
          fall = prev[i][3] && !o[3];
          since[i]++;
          if (o[3] != prev[i][3]) begin
            check(nm(i, "bclk half period"), since[i], d);
            since[i] = 0;
          end
          if (o[2:1] != prev[i][2:1]) check(nm(i, "sdata/lrclk move only on bclk fall"), fall, 1);
          if (rise) begin
            check(nm(i, "setup at bclk rise"), o[2:1], prev[i][2:1]);
            rcount[i]++;
            if (rcount[i] == 0) begin
              check(nm(i, "idle bit before first frame"), o[2:1], 0);
            end else begin
              n = (rcount[i] - 1) % 32;
              check(nm(i, $sformatf("lrclk bit %0d", n)), o[2], (n >= 15 && n <= 30));
              acc[i] = {acc[i][30:0], o[1]};
              if (n == 31) begin
                got_exp = 1'b0;
                if (i == 0 && exp_q0.size() > 0) begin exp_f = exp_q0.pop_front(); got_exp = 1'b1; end
                if (i == 1 && exp_q1.size() > 0) begin exp_f = exp_q1.pop_front(); got_exp = 1'b1; end
                if (got_exp) begin
                  check(nm(i, "frame"), acc[i], exp_f);
                end else begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL %s: got %h with no frame expected", nm(i, "frame"), acc[i]);
                end
              end
            end
          end
          exp_sb = fall && rcount[i] >= 0 && (rcount[i] % 32) == 0;
          if (o[0] || exp_sb) check(nm(i, "sample_strobe"), o[0], exp_sb);
          if (o[0]) begin
            if (last_s[i] >= 0) check(nm(i, "strobe period"), cyc - last_s[i], 64 * d);
            last_s[i] = cyc;
          end
        end
        prev[i] = o;
      end
    end
  end

  initial begin
    vecs[0] = '{0, 12'hFFF, 12'h000, 16'h7FF0, 16'h8000};
    vecs[1] = '{0, 12'h800, 12'h7FF, 16'h0000, 16'hFFF0};
    vecs[2] = '{0, 12'h123, 12'hABC, 16'h9230, 16'h2BC0};
    vecs[3] = '{0, 12'h5A5, 12'hA5A, 16'hDA50, 16'h25A0};
    vecs[4] = '{1, 12'h801, 12'h7FF, 16'h8010, 16'h7FF0};
    vecs[5] = '{1, 12'h000, 12'hFFF, 16'h0000, 16'hFFF0};
    vecs[6] = '{1, 12'h3C3, 12'hC3C, 16'h3C30, 16'hC3C0};
    vecs[7] = '{1, 12'hFFF, 12'h800, 16'hFFF0, 16'h8000};

    en_v = '0; l_v = '0; r_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("a outputs in reset", out_v[0], 0);
    check("b outputs in reset", out_v[1], 0);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("a outputs idle after release", out_v[0], 0);
    check("b outputs idle after release", out_v[1], 0);
    mon_on = 1'b1;

    // Table runs: each next sample is driven at bit 5 of the frame in flight.
    start_run(0);
    finish_run(0, 4);
    start_run(4);
    finish_run(4, 4);

    // enable low for 3 clk at bit 10, then a fresh frame.
    start_run(0);
    goto_edge(2 * DIV_A * 11);
    en_v[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      goto_edge(2 * DIV_A * 11 + k);
      check($sformatf("a outputs with enable low, clk %0d", k), out_v[0], 0);
    end
    exp_q0.delete();
    load_vec(2);
    en_v[0] = 1'b1;
    edge_n = 0;
    finish_run(2, 1);

    // nreset pulse at bit 20 while bclk and lrclk are both high.
    start_run(1);
    goto_edge(2 * DIV_A * 21 + DIV_A);
    nreset = 1'b0;
    #1;
    check("a async reset clears outputs", out_v[0], 0);
    check("b async reset clears outputs", out_v[1], 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    exp_q0.delete();
    load_vec(3);
    edge_n = 0;
    finish_run(3, 1);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
